// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data load/store.
// Latency: grant at cycle 0, mem_en at 1, read data at 1+MEM_LAT, ack at 2+MEM_LAT.
// Backpressure: requesters hold req until their one-cycle ack; stall_* freeze the pipeline meanwhile.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic              dm_byte,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic                own_if;
    logic                drop;
    logic [SC_W-1:0]     starve_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_we;
    logic                lat_byte;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;

    logic if_req_eff;
    logic grant_any;
    logic grant_if;
    logic last_wait;

    // A fetch raised together with a flush is already stale, so it never competes.
    assign if_req_eff = if_req & ~if_flush;
    assign grant_any  = if_req_eff | dm_req;
    assign grant_if   = if_req_eff & (~dm_req | (starve_cnt == SC_W'(STARVE_MAX)));
    assign last_wait  = (state == WAIT) && (lat_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_if     <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_byte   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (state == IDLE) begin
                drop <= 1'b0;
                if (grant_any) begin
                    own_if    <= grant_if;
                    lat_addr  <= grant_if ? if_addr : dm_addr;
                    lat_wdata <= grant_if ? '0 : dm_wdata;
                    lat_we    <= ~grant_if & dm_wr;
                    lat_byte  <= ~grant_if & dm_byte;
                end
                if (grant_if) begin
                    starve_cnt <= '0;
                end else if (grant_any && if_req_eff) begin
                    if (starve_cnt != SC_W'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
                end else if (!if_req_eff) begin
                    starve_cnt <= '0;
                end
            end else if (own_if && if_flush) begin
                drop <= 1'b1;
            end

            if (state == ISSUE) begin
                lat_cnt <= LAT_W'(MEM_LAT - 1);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            // Read data is only valid in the final wait cycle; stores leave dm_rdata alone.
            if (last_wait) begin
                if (own_if && !drop && !if_flush) begin
                    if_rdata_q <= mem_rdata;
                end
                if (!own_if && !lat_we) begin
                    dm_rdata_q <= lat_byte ? {{(DATA_W-8){1'b0}}, mem_rdata[7:0]} : mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & lat_we;
    assign mem_byte  = mem_en & lat_byte;
    assign mem_addr  = mem_en ? lat_addr : '0;
    assign mem_wdata = mem_en ? lat_wdata : '0;

    assign if_ack    = (state == DONE) & own_if & ~drop & ~if_flush;
    assign dm_ack    = (state == DONE) & ~own_if;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requesters push expected responses, a monitor pops them on each ack.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, if_ack;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_wr, dm_byte, dm_ack;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              mem_en, mem_we, mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              stall_if, stall_mem;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Memory: backing store plus a read-return pipeline; invalid cycles carry junk.
    logic [DATA_W-1:0] mem    [256];
    logic [DATA_W-1:0] ref_dm [256];
    logic [DATA_W:0]   pipe   [MEM_LAT];
    logic [DATA_W-1:0] junk;

    initial begin
        for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'($urandom);
            ref_dm[i] = mem[i];
        end
    end

    always @(posedge clk) begin
        junk <= 16'($urandom);
        for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= '0;
        if (mem_en) begin
            if (mem_we) begin
                if (mem_byte) mem[mem_addr][7:0] = mem_wdata[7:0];
                else          mem[mem_addr]      = mem_wdata;
            end else if (mem_byte) begin
                pipe[0] <= {1'b1, 8'($urandom), mem[mem_addr][7:0]};
            end else begin
                pipe[0] <= {1'b1, mem[mem_addr]};
            end
        end
    end

    assign mem_rdata = pipe[MEM_LAT-1][DATA_W] ? pipe[MEM_LAT-1][DATA_W-1:0] : junk;

    // Reference model: fetches read instruction memory; data ops apply in program order.
    logic [DATA_W-1:0] if_q [$];
    logic [DATA_W-1:0] dm_q [$];
    bit                ack_log [$];
    logic [DATA_W-1:0] last_load = '0;

    task automatic set_word(input logic [7:0] a, input logic [15:0] d);
        mem[a]    = d;
        ref_dm[a] = d;
    endtask

    task automatic dm_expect(input logic wr, input logic byt, input logic [7:0] a, input logic [15:0] wd);
        if (wr) begin
            if (byt) ref_dm[a][7:0] = wd[7:0];
            else     ref_dm[a]      = wd;
        end else begin
            last_load = byt ? {8'h00, ref_dm[a][7:0]} : ref_dm[a];
        end
        dm_q.push_back(last_load);
    endtask

    // Monitor
    logic              prev_en = 1'b0;
    logic              last_we, last_byte;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;

    always @(negedge clk) begin
        if (!rst) begin
            if (if_ack) begin
                ack_log.push_back(1'b1);
                if (if_q.size() == 0) check("if_ack_unexpected", 1, 0);
                else                  check("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_ack) begin
                ack_log.push_back(1'b0);
                if (dm_q.size() == 0) check("dm_ack_unexpected", 1, 0);
                else                  check("dm_rdata", dm_rdata, dm_q.pop_front());
            end
            if (mem_en) begin
                check("mem_en_one_cycle", prev_en, 0);
                last_we    = mem_we;
                last_byte  = mem_byte;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
            end
            if (if_req) check("stall_if", stall_if, !if_ack);
            if (dm_req) check("stall_mem", stall_mem, !dm_ack);
        end
        prev_en = mem_en;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if();
        bit got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = if_ack;
        end
        if (!got) check("if_ack_timeout", 0, 1);
        next_cycle();
        if_req = 1'b0;
    endtask

    task automatic wait_dm();
        bit got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = dm_ack;
        end
        if (!got) check("dm_ack_timeout", 0, 1);
        next_cycle();
        dm_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] a);
        if_req  = 1'b1;
        if_addr = a;
        if_q.push_back(mem[a]);
        wait_if();
    endtask

    task automatic do_dm(input logic wr, input logic byt, input logic [7:0] a, input logic [15:0] wd);
        dm_req   = 1'b1;
        dm_wr    = wr;
        dm_byte  = byt;
        dm_addr  = a;
        dm_wdata = wd;
        dm_expect(wr, byt, a, wd);
        wait_dm();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_wr = 0; dm_byte = 0; dm_addr = 0; dm_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acks", {if_ack, dm_ack}, 0);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        check("rst_mem", {mem_en, mem_we, mem_byte, mem_addr, mem_wdata}, 0);
        check("rst_stall", {stall_if, stall_mem}, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single fetch timing
        set_word(8'h04, 16'h1234);
        if_req = 1'b1; if_addr = 8'h04;
        if_q.push_back(16'h1234);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("t1_stall_if", stall_if, k < 4);
            check("t1_mem_en", mem_en, k == 1);
            if (k == 1) check("t1_mem_addr", {mem_we, mem_addr}, {1'b0, 8'h04});
            check("t1_if_ack", if_ack, k == 4);
            next_cycle();
        end
        if_req = 1'b0;
        next_cycle();

        // Simultaneous requests: DM first, then IF
        set_word(8'h20, 16'hBEEF);
        set_word(8'h08, 16'h5A5A);
        if_req = 1'b1; if_addr = 8'h08;
        if_q.push_back(16'h5A5A);
        dm_req = 1'b1; dm_wr = 0; dm_byte = 0; dm_addr = 8'h20;
        dm_expect(1'b0, 1'b0, 8'h20, 16'h0);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check("t2_dm_ack", dm_ack, k == 4);
            check("t2_if_ack", if_ack, k == 9);
            check("t2_mem_en", mem_en, k == 1 || k == 6);
            if (k == 1) check("t2_mem_addr_dm", mem_addr, 8'h20);
            if (k == 6) check("t2_mem_addr_if", mem_addr, 8'h08);
            next_cycle();
            if (k == 4) dm_req = 1'b0;
        end
        if_req = 1'b0;
        next_cycle();

        // Flush during WAIT drops the fetch
        set_word(8'h0C, 16'h1111);
        set_word(8'h10, 16'h2222);
        if_req = 1'b1; if_addr = 8'h0C;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("t5_mem_en", mem_en, k == 1);
            check("t5_no_if_ack", if_ack, 0);
            if (k >= 4) check("t5_if_rdata_held", if_rdata, 16'h5A5A);
            next_cycle();
            if (k == 1) begin if_flush = 1'b1; if_req = 1'b0; end
            if (k == 2) if_flush = 1'b0;
        end
        do_fetch(8'h10);
        check("t5_refetch", if_rdata, 16'h2222);

        // Byte load then byte store
        set_word(8'h90, 16'h33A5);
        do_dm(1'b0, 1'b1, 8'h90, 16'h0);
        check("t4_load_lane", {last_we, last_byte}, 2'b01);
        check("t4_load_zext", dm_rdata, 16'h00A5);
        do_dm(1'b1, 1'b1, 8'h91, 16'h0077);
        check("t4_store_lane", {last_we, last_byte}, 2'b11);
        check("t4_store_wdata", last_wdata, 16'h0077);
        check("t4_store_keeps_rdata", dm_rdata, 16'h00A5);
        next_cycle();

        // Starvation: three DM grants, forced IF, counter restarts
        ack_log.delete();
        fork
            begin
                for (int i = 0; i < 5; i++) do_dm(1'b0, 1'b0, 8'(8'hA0 + i), 16'h0);
            end
            begin
                do_fetch(8'h30);
                do_fetch(8'h31);
            end
        join
        begin
            bit exp_order [7] = '{0, 0, 0, 1, 0, 0, 1};
            check("t3_ack_count", ack_log.size(), 7);
            for (int i = 0; i < 7 && i < ack_log.size(); i++)
                check($sformatf("t3_grant_%0d", i), ack_log[i], exp_order[i]);
        end
        next_cycle();
        next_cycle();

        // Reset in the middle of a DM load
        dm_req = 1'b1; dm_wr = 0; dm_byte = 0; dm_addr = 8'h84;
        next_cycle();
        next_cycle();
        rst = 1'b1; dm_req = 1'b0;
        last_load = '0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_acks", {if_ack, dm_ack}, 0);
        check("t6_mem", {mem_en, mem_we, mem_byte, mem_addr, mem_wdata}, 0);
        check("t6_rdata", {if_rdata, dm_rdata}, 0);
        check("t6_stall", {stall_if, stall_mem}, 0);
        next_cycle();
        dm_req = 1'b1; dm_addr = 8'h86;
        dm_expect(1'b0, 1'b0, 8'h86, 16'h0);
        @(negedge clk);
        check("t6_no_early_en", mem_en, 0);
        next_cycle();
        @(negedge clk);
        check("t6_mem_en", {mem_en, mem_addr}, {1'b1, 8'h86});
        wait_dm();

        // Random concurrent traffic: IF reads low half, DM reads/writes upper half
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) next_cycle();
                    do_fetch(8'($urandom_range(0, 127)));
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) next_cycle();
                    do_dm(1'($urandom), 1'($urandom), 8'($urandom_range(128, 143)), 16'($urandom));
                end
            end
        join
        repeat (3) next_cycle();
        check("if_queue_drained", if_q.size(), 0);
        check("dm_queue_drained", dm_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the CPU's single-port unified memory. It shares the one memory port between the IF stage's instruction fetch and the MEM stage's load/store. It issues one transaction at a time against a fixed-latency memory and returns data with a one-cycle acknowledge. It also drives the stall signals the pipeline uses to freeze IF and MEM while their access is outstanding.

## Interface
- ADDR_W, 8, address width; matches the PC width.
- DATA_W, 16, memory word width.
- MEM_LAT, 2, memory read latency in cycles; must be 1 or more.
- STARVE_MAX, 3, number of consecutive DM grants made while IF waits before IF is forced through.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  instruction fetch request; held with stable if_addr until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  branch/jump flush; cancels the in-flight fetch.
- if_rdata  out  DATA_W  fetched instruction; valid with if_ack.
- if_ack  out  1  one-cycle completion pulse.
- dm_req  in  1  data request; held with stable dm_* until dm_ack.
- dm_wr  in  1  1 = store, 0 = load.
- dm_byte  in  1  byte access (LoadByte/store byte).
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid with dm_ack.
- dm_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe, high for exactly one cycle.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_byte  out  1  byte lane select.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data. Valid MEM_LAT cycles after the mem_en cycle. A byte read returns the selected byte in bits [7:0].
- stall_if  out  1  = if_req & ~if_ack.
- stall_mem  out  1  = dm_req & ~dm_ack.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Grant owner is registered as IF or DM.
- IDLE: on the cycle any request is sampled, choose the owner, latch address/data/control, and go to ISSUE.
- Arbitration:
  - IF is chosen if only if_req is high.
  - DM is chosen if only dm_req is high.
  - If both are high, DM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - An if_req sampled in the same cycle as if_flush is ignored.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each DM grant made while if_req is high.
  - Clears to 0 on an IF grant.
  - Clears to 0 in any IDLE cycle with if_req low.
- ISSUE: mem_en = 1 with the latched mem_* values; load the latency counter; go to WAIT.
- WAIT: count MEM_LAT cycles. In the last count cycle mem_rdata is valid; capture it and go to DONE.
- DONE: pulse the owner's ack and drive the captured rdata; always return to IDLE.
  - The requester's req is still high during the ack cycle. It is never re-sampled there, so a new request can only be granted from the following IDLE cycle.
- Load return formatting:
  - dm_byte load: dm_rdata = {8'h00, mem_rdata[7:0]} (zero-extended).
  - Word load: dm_rdata = mem_rdata.
- Stores: follow the same state sequence. dm_ack is given in DONE; dm_rdata holds its previous value.
- Flush:
  - if_flush high in any cycle while the owner is IF (ISSUE/WAIT/DONE) sets a drop flag.
  - When the flag is set, the memory access still completes, if_ack is suppressed, and if_rdata is not updated.
  - The drop flag clears on return to IDLE.
  - if_flush has no effect on DM transactions.
- if_rdata and dm_rdata hold their values between acks.

## Timing
- Reset state: IDLE, starve_cnt = 0, drop flag = 0. Every output is 0, including if_rdata, dm_rdata, mem_* and the acks.
- Latency, with the request first sampled in IDLE at cycle 0:
  - mem_en in cycle 1.
  - mem_rdata valid in cycle 1+MEM_LAT.
  - ack in cycle 2+MEM_LAT.
  - Next grant decided in cycle 3+MEM_LAT at the earliest.
- Throughput: one transaction per MEM_LAT+3 cycles.
- rst mid-transaction: abandon immediately, with no ack and no rdata update. A late memory response is ignored.
- A request dropped before its ack is a protocol violation; the transaction still completes and its ack is still pulsed.

## Test plan
- Single fetch (MEM_LAT=2): if_req with if_addr=0x04 in cycle 0, memory returns 0x1234 → mem_en in cycle 1 with mem_addr=0x04; if_ack in cycle 4 with if_rdata=0x1234; stall_if=1 in cycles 0–3.
- Simultaneous requests: if_req and dm_req both high, DM load at 0x20 returns 0xBEEF → DM served first (dm_ack cycle 4); IF mem_en in cycle 6; if_ack in cycle 9.
- Starvation: dm_req held continuously with back-to-back loads and if_req held → three DM grants, then the 4th grant goes to IF; starve_cnt returns to 0.
- Byte load: dm_byte=1, dm_wr=0, mem_rdata=0x00A5 → dm_rdata=0x00A5, mem_byte=1. A following byte store with dm_wdata=0x0077 → mem_we=1, mem_byte=1, and dm_rdata stays 0x00A5.
- Flush: if_flush pulsed in cycle 2 of an IF fetch → mem_en still issued, no if_ack, if_rdata unchanged; a new fetch at 0x10 completes normally.
- Reset mid-WAIT: rst in cycle 2 of a DM load → no dm_ack, all outputs 0 in cycle 3; a request in cycle 4 is granted with mem_en in cycle 5.
